// File: rtl/nxd_responder_if.sv
// CPU IO bus / device-ack bundle seen by the NXD responder.
// The master side is the CPU plus the OR'd device lines; the responder is the slave.
interface nxd_responder_if #(
    parameter int unsigned ADDR_WIDTH = 22,
    parameter int unsigned DATA_WIDTH = 36
);
    logic                  busREQ;
    logic                  busIO;
    logic [ADDR_WIDTH-1:0] busADDR;
    logic                  devACK;
    logic [DATA_WIDTH-1:0] devDATA;
    logic                  clrNXD;
    logic                  busACK;
    logic [DATA_WIDTH-1:0] busDATA;
    logic                  nxd;
    logic [ADDR_WIDTH-1:0] nxdADDR;

    modport master (
        output busREQ, busIO, busADDR, devACK, devDATA, clrNXD,
        input  busACK, busDATA, nxd, nxdADDR
    );

    modport slave (
        input  busREQ, busIO, busADDR, devACK, devDATA, clrNXD,
        output busACK, busDATA, nxd, nxdADDR
    );
endinterface

// File: rtl/nxd_responder.sv
// IO bus responder: forwards device acks to the CPU and completes unclaimed IO cycles
// with zero data after a timeout, latching a sticky non-existent-device flag.
module nxd_responder #(
    parameter int unsigned TIMEOUT    = 63,
    parameter int unsigned ADDR_WIDTH = 22,
    parameter int unsigned DATA_WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clken,
    nxd_responder_if.slave   bus
);
    localparam int unsigned CntWidth = $clog2(TIMEOUT);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StWait, StAck, StNxd, StHold} state_e;

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  bus_ack_q, bus_ack_d;
    logic [DATA_WIDTH-1:0] bus_data_q, bus_data_d;
    logic                  nxd_q, nxd_d;
    logic [ADDR_WIDTH-1:0] nxd_addr_q, nxd_addr_d;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        addr_d     = addr_q;
        bus_ack_d  = bus_ack_q;
        bus_data_d = bus_data_q;
        nxd_d      = nxd_q;
        nxd_addr_d = nxd_addr_q;
        if (clken) begin
            bus_ack_d = 1'b0;
            // Clear first so a same-edge NXD entry below overrides it.
            if (bus.clrNXD) begin
                nxd_d = 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (bus.busREQ && bus.busIO) begin
                        state_d = StWait;
                        count_d = '0;
                        addr_d  = bus.busADDR;
                    end
                end
                StWait: begin
                    if (!bus.busREQ) begin
                        state_d = StIdle;
                    end else if (bus.devACK) begin
                        state_d    = StAck;
                        bus_data_d = bus.devDATA;
                    end else if (count_q == CntLast) begin
                        state_d    = StNxd;
                        bus_data_d = '0;
                        nxd_d      = 1'b1;
                        nxd_addr_d = addr_q;
                    end else begin
                        count_d = count_q + CntWidth'(1);
                    end
                end
                StAck, StNxd: begin
                    bus_ack_d = 1'b1;
                    state_d   = StHold;
                end
                StHold: begin
                    // Wait for the CPU to drop the request so it is served only once.
                    if (!bus.busREQ) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            count_q    <= '0;
            addr_q     <= '0;
            bus_ack_q  <= 1'b0;
            bus_data_q <= '0;
            nxd_q      <= 1'b0;
            nxd_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            bus_ack_q  <= bus_ack_d;
            bus_data_q <= bus_data_d;
            nxd_q      <= nxd_d;
            nxd_addr_q <= nxd_addr_d;
        end
    end

    assign bus.busACK  = bus_ack_q;
    assign bus.busDATA = bus_data_q;
    assign bus.nxd     = nxd_q;
    assign bus.nxdADDR = nxd_addr_q;
endmodule
